// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Also holds the decode of EXU control-flow flags into PC update selects.
package pc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_EXEC     = 3'd3,
    ST_UPDATE   = 3'd4,
    ST_TRAP     = 3'd5,
    ST_HALT     = 3'd6
  } state_t;

  localparam logic [1:0] PC_SEL_ADDER = 2'b00;
  localparam logic [1:0] PC_SEL_MTVEC = 2'b01;
  localparam logic [1:0] PC_SEL_MEPC  = 2'b11;

  localparam logic [3:0] CAUSE_IAF     = 4'd1;
  localparam logic [3:0] CAUSE_ECALL_M = 4'd11;

  typedef struct packed {
    logic [1:0] sel;
    logic       left_rs1;
    logic       right_imm;
  } upd_sel_t;

  // Priority mret > jalr > jal > taken branch > sequential (pc + 4).
  function automatic upd_sel_t decode_update(input logic mret, input logic jalr,
                                             input logic jal, input logic br_taken);
    upd_sel_t s;
    s = '0;
    if (mret) begin
      s.sel = PC_SEL_MEPC;
    end else if (jalr) begin
      s.left_rs1  = 1'b1;
      s.right_imm = 1'b1;
    end else if (jal || br_taken) begin
      s.right_imm = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/pc_ctrl_instret_counter.sv
// Retired-instruction counter: synchronous active-low clear, increment enable,
// wraps modulo 2^CNT_W.
module instret_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter sequencer: fetch -> execute -> PC update loop with traps,
// ebreak halt and retired-instruction counting. All outputs decode registered state.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  // Handshake: a fetch transfers on a cycle with ifu_req_valid && ifu_req_ready;
  // valid, once raised, holds until that cycle. The response is one
  // ifu_rsp_valid pulse; exu_start is a one-cycle pulse answered by exu_done.
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  input  logic             ifu_rsp_valid,
  input  logic             ifu_rsp_err,
  output logic             exu_start,
  input  logic             exu_done,
  input  logic             exu_jal,
  input  logic             exu_jalr,
  input  logic             exu_br_taken,
  input  logic             exu_ecall,
  input  logic             exu_mret,
  input  logic             exu_ebreak,
  output logic             pc_valid,
  output logic [1:0]       pc_sel,
  output logic             adder_left_rs1,
  output logic             adder_right_imm,
  output logic             trap_valid,
  output logic [3:0]       trap_cause,
  output logic             halted,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state_dbg
);

  state_t     state_q;
  logic       start_q;
  upd_sel_t   upd_q;
  logic [3:0] cause_q;
  logic       instret_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      upd_q   <= '0;
      cause_q <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE:  state_q <= ST_FETCH;
        ST_FETCH: if (ifu_req_ready) state_q <= ST_WAIT_RSP;
        ST_WAIT_RSP: begin
          if (ifu_rsp_valid) begin
            if (ifu_rsp_err) begin
              state_q <= ST_TRAP;
              cause_q <= CAUSE_IAF;
            end else begin
              state_q <= ST_EXEC;
              start_q <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (exu_done) begin
            if (exu_ebreak) begin
              state_q <= ST_HALT;
            end else if (exu_ecall) begin
              state_q <= ST_TRAP;
              cause_q <= CAUSE_ECALL_M;
            end else begin
              state_q <= ST_UPDATE;
              upd_q   <= decode_update(exu_mret, exu_jalr, exu_jal, exu_br_taken);
            end
          end
        end
        ST_UPDATE: state_q <= ST_FETCH;
        ST_TRAP:   state_q <= ST_FETCH;
        ST_HALT:   state_q <= ST_HALT;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // ecall traps without retiring; ebreak retires even though it halts.
  assign instret_inc = (state_q == ST_EXEC) && exu_done && (exu_ebreak || !exu_ecall);

  instret_counter #(.CNT_W(CNT_W)) u_instret (
    .clk   (clk),
    .clr_n (rst_n),
    .inc   (instret_inc),
    .count (instret)
  );

  assign ifu_req_valid   = (state_q == ST_FETCH);
  assign exu_start       = start_q;
  assign pc_valid        = (state_q == ST_UPDATE) || (state_q == ST_TRAP);
  assign pc_sel          = (state_q == ST_UPDATE) ? upd_q.sel :
                           (state_q == ST_TRAP)   ? PC_SEL_MTVEC : PC_SEL_ADDER;
  assign adder_left_rs1  = (state_q == ST_UPDATE) && upd_q.left_rs1;
  assign adder_right_imm = (state_q == ST_UPDATE) && upd_q.right_imm;
  assign trap_valid      = (state_q == ST_TRAP);
  assign trap_cause      = (state_q == ST_TRAP) ? cause_q : 4'd0;
  assign halted          = (state_q == ST_HALT);
  assign state_dbg       = state_q;

endmodule
